// File: rtl/line_follow_ctrl.sv
// N-sensor line-following steering controller: filtered tracker inputs,
// proportional wheel duty, directed search with timeout, obstacle halt/resume.
module line_follow_ctrl #(
    parameter int N_SENS       = 5,
    parameter int DUTY_W       = 10,
    parameter int DUTY_FAST    = 800,
    parameter int DUTY_STEP    = 200,
    parameter int DUTY_SEARCH  = 500,
    parameter int FILT_LEN     = 4,
    parameter int LOST_TIMEOUT = 100,
    parameter int CLEAR_CYC    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [N_SENS-1:0] sensors,
    input  logic              stop_req,
    output logic [DUTY_W-1:0] left_duty,
    output logic [DUTY_W-1:0] right_duty,
    output logic [1:0]        left_dir,
    output logic [1:0]        right_dir,
    output logic [2:0]        state_o,
    output logic              lost
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int SW = $clog2(LOST_TIMEOUT + 1);
    localparam int CW = $clog2(CLEAR_CYC + 1);
    localparam int IW = $clog2(N_SENS);
    localparam int PW = DUTY_W + 4;
    localparam logic [IW:0] CTR = (IW + 1)'(N_SENS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0, TRACK = 3'd1, SEARCH_L = 3'd2,
        SEARCH_R = 3'd3, HALT = 3'd4, FAULT = 3'd5
    } state_t;
    typedef enum logic [1:0] {SIDE_C, SIDE_L, SIDE_R} side_t;

    state_t            state, state_n, ret, ret_n;
    side_t             side, side_n;
    logic [SW-1:0]     scnt, scnt_n;
    logic [CW-1:0]     ccnt, ccnt_n;
    logic [N_SENS-1:0] filt;
    logic [FW-1:0]     fcnt [N_SENS];

    // Filter keeps running in every state so the line is already settled
    // by the time the controller is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= '0;
            for (int i = 0; i < N_SENS; i++) fcnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_SENS; i++) begin
                if (sensors[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
                    filt[i] <= sensors[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    logic [IW-1:0]     lo, hi;
    logic [IW:0]       sum, mag;
    logic              any, off_neg, off_pos;
    logic [PW-1:0]     prod;
    logic [DUTY_W-1:0] inner;

    always_comb begin
        lo = '0;
        hi = '0;
        for (int i = N_SENS - 1; i >= 0; i--) if (filt[i]) lo = IW'(i);
        for (int i = 0; i < N_SENS; i++)      if (filt[i]) hi = IW'(i);
        any     = |filt;
        sum     = {1'b0, lo} + {1'b0, hi};
        off_neg = sum < CTR;
        off_pos = sum > CTR;
        mag     = off_neg ? (CTR - sum) : (sum - CTR);
        prod    = PW'(mag) * PW'(DUTY_STEP);
        inner   = (prod >= PW'(DUTY_FAST)) ? '0 : DUTY_W'(PW'(DUTY_FAST) - prod);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ret   <= IDLE;
            side  <= SIDE_C;
            scnt  <= '0;
            ccnt  <= '0;
        end else begin
            state <= state_n;
            ret   <= ret_n;
            side  <= side_n;
            scnt  <= scnt_n;
            ccnt  <= ccnt_n;
        end
    end

    always_comb begin
        state_n = state;
        ret_n   = ret;
        side_n  = side;
        scnt_n  = scnt;
        ccnt_n  = ccnt;
        if (!enable) begin
            state_n = IDLE;
            side_n  = SIDE_C;
            scnt_n  = '0;
            ccnt_n  = '0;
        end else begin
            case (state)
                IDLE: state_n = TRACK;
                TRACK, SEARCH_L, SEARCH_R: begin
                    if (stop_req) begin
                        state_n = HALT;
                        ret_n   = state;
                        ccnt_n  = '0;
                    end else if (state == TRACK) begin
                        if (any) begin
                            if (off_neg) side_n = SIDE_L;
                            if (off_pos) side_n = SIDE_R;
                        end else begin
                            scnt_n  = '0;
                            state_n = (side == SIDE_L) ? SEARCH_L :
                                      (side == SIDE_R) ? SEARCH_R : FAULT;
                        end
                    end else if (any) begin
                        state_n = TRACK;
                    end else if (scnt == SW'(LOST_TIMEOUT - 1)) begin
                        state_n = FAULT;
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
                // search counter is deliberately left untouched while halted
                HALT: begin
                    if (stop_req) begin
                        ccnt_n = '0;
                    end else if (ccnt == CW'(CLEAR_CYC - 1)) begin
                        state_n = ret;
                        ccnt_n  = '0;
                    end else begin
                        ccnt_n = ccnt + 1'b1;
                    end
                end
                FAULT:   state_n = FAULT;
                default: state_n = IDLE;
            endcase
        end
    end

    logic [DUTY_W-1:0] ld_n, rd_n;
    logic [1:0]        ldir_n, rdir_n;

    always_comb begin
        ld_n   = '0;
        rd_n   = '0;
        ldir_n = 2'b00;
        rdir_n = 2'b00;
        case (state)
            TRACK: if (any) begin
                ldir_n = 2'b01;
                rdir_n = 2'b01;
                ld_n   = off_neg ? inner : DUTY_W'(DUTY_FAST);
                rd_n   = off_pos ? inner : DUTY_W'(DUTY_FAST);
            end
            SEARCH_L: begin
                ldir_n = 2'b10;
                rdir_n = 2'b01;
                ld_n   = DUTY_W'(DUTY_SEARCH);
                rd_n   = DUTY_W'(DUTY_SEARCH);
            end
            SEARCH_R: begin
                ldir_n = 2'b01;
                rdir_n = 2'b10;
                ld_n   = DUTY_W'(DUTY_SEARCH);
                rd_n   = DUTY_W'(DUTY_SEARCH);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            left_duty  <= '0;
            right_duty <= '0;
            left_dir   <= 2'b00;
            right_dir  <= 2'b00;
            state_o    <= 3'd0;
            lost       <= 1'b0;
        end else begin
            left_duty  <= ld_n;
            right_duty <= rd_n;
            left_dir   <= ldir_n;
            right_dir  <= rdir_n;
            state_o    <= state;
            lost       <= (state == SEARCH_L) || (state == SEARCH_R) || (state == FAULT);
        end
    end
endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl; a second instance with a steeper
// duty step exercises the clamp-at-zero path.
module tb_line_follow_ctrl;
    logic       clk = 1'b0;
    logic       rst, enable, stop_req;
    logic [4:0] sensors;
    logic [9:0] left_duty, right_duty, left_duty3, right_duty3;
    logic [1:0] left_dir, right_dir, left_dir3, right_dir3;
    logic [2:0] state_o, state_o3;
    logic       lost, lost3;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    line_follow_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .sensors(sensors), .stop_req(stop_req),
        .left_duty(left_duty), .right_duty(right_duty), .left_dir(left_dir),
        .right_dir(right_dir), .state_o(state_o), .lost(lost)
    );

    line_follow_ctrl #(.DUTY_STEP(300)) dut3 (
        .clk(clk), .rst(rst), .enable(enable), .sensors(sensors), .stop_req(stop_req),
        .left_duty(left_duty3), .right_duty(right_duty3), .left_dir(left_dir3),
        .right_dir(right_dir3), .state_o(state_o3), .lost(lost3)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int st, input int ld, input int rd,
                           input int ldir, input int rdir, input int ls);
        chk({tag, ".state"}, state_o, st);
        chk({tag, ".ld"}, left_duty, ld);
        chk({tag, ".rd"}, right_duty, rd);
        chk({tag, ".ldir"}, left_dir, ldir);
        chk({tag, ".rdir"}, right_dir, rdir);
        chk({tag, ".lost"}, lost, ls);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; stop_req = 1'b0; sensors = 5'b00100;
        step(2);
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(5);                       // let the filter settle on the centre line
        enable = 1'b1;
        step(2);
        chk_out("track_c", 1, 800, 800, 1, 1, 0);

        // offset steering and filter latency
        sensors = 5'b00001;
        step(4);
        chk("lat_hold.ld", left_duty, 800);
        step(1);
        chk_out("off_m4", 1, 0, 800, 1, 1, 0);
        chk("off_m4_s300.ld", left_duty3, 0);
        sensors = 5'b00011;
        step(5);
        chk_out("off_m3", 1, 200, 800, 1, 1, 0);
        chk("off_m3_s300.ld", left_duty3, 0);
        sensors = 5'b01000;
        step(5);
        chk_out("off_p2", 1, 800, 400, 1, 1, 0);
        chk("off_p2_s300.rd", right_duty3, 200);
        sensors = 5'b00100;
        step(5);
        chk_out("back_c", 1, 800, 800, 1, 1, 0);

        // glitch rejection
        sensors = 5'b01100; step(1);
        sensors = 5'b00100; step(6);
        chk("glitch1.rd", right_duty, 800);
        sensors = 5'b01100; step(3);
        sensors = 5'b00100; step(6);
        chk("glitch3.rd", right_duty, 800);
        sensors = 5'b01100; step(4);
        chk("chg4_c4.rd", right_duty, 800);
        step(1);
        chk("chg4_c5.rd", right_duty, 600);

        // lost line, right side, runs into timeout
        sensors = 5'b00000;
        step(6);
        chk_out("search_r", 3, 500, 500, 1, 2, 1);
        step(99);
        chk("search_r_last.state", state_o, 3);
        step(1);
        chk_out("fault", 5, 0, 0, 0, 0, 1);
        enable = 1'b0;
        step(2);
        chk_out("fault_idle", 0, 0, 0, 0, 0, 0);

        // lost line, reacquired at search cycle 60
        sensors = 5'b01100;
        step(5);
        enable = 1'b1;
        step(2);
        chk("retrack.state", state_o, 1);
        sensors = 5'b00000;
        step(6);
        chk("search_r2.state", state_o, 3);
        step(54);
        sensors = 5'b01100;
        step(5);
        chk("reacq_pre.state", state_o, 3);
        step(1);
        chk_out("reacq", 1, 800, 600, 1, 1, 0);

        // obstacle halt with interrupted clearance
        stop_req = 1'b1; step(2);
        chk_out("halt", 4, 0, 0, 0, 0, 0);
        stop_req = 1'b0; step(5);
        stop_req = 1'b1; step(1);
        stop_req = 1'b0; step(7);
        chk("halt_low7.state", state_o, 4);
        step(1);
        chk("halt_low8.state", state_o, 4);
        step(1);
        chk_out("resume", 1, 800, 600, 1, 1, 0);

        // halt from SEARCH_L keeps the search count
        sensors = 5'b00110;
        step(5);
        chk_out("off_m1", 1, 600, 800, 1, 1, 0);
        sensors = 5'b00000;
        step(6);
        chk_out("search_l", 2, 500, 500, 2, 1, 1);
        step(49);
        stop_req = 1'b1; step(1);
        stop_req = 1'b0; step(1);
        chk_out("halt_sl", 4, 0, 0, 0, 0, 0);
        step(7);
        chk("halt_sl_end.state", state_o, 4);
        step(1);
        chk("resume_sl.state", state_o, 2);
        step(49);
        chk("sl_cnt_kept.state", state_o, 2);
        step(1);
        chk("sl_fault.state", state_o, 5);

        // enable dropped in HALT
        enable = 1'b0;
        sensors = 5'b01100;
        step(5);
        enable = 1'b1;
        step(2);
        stop_req = 1'b1; step(2);
        chk("halt2.state", state_o, 4);
        enable = 1'b0; step(2);
        chk_out("halt_dis", 0, 0, 0, 0, 0, 0);

        // reset while searching
        stop_req = 1'b0; enable = 1'b1;
        step(3);
        sensors = 5'b00000;
        step(6);
        chk("search_r3.state", state_o, 3);
        rst = 1'b1; step(1);
        chk_out("rst_search", 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/line_follow_ctrl.md
Name: line_follow_ctrl

Overview:
Parametrised line-following steering controller for the car platform. It generalises the fixed 3-sensor tracker/mode logic to N tracker sensors. It outputs proportional per-wheel PWM duty values instead of discrete modes, and adds:
- per-sensor input filtering,
- directed search when the line is lost, with a timeout fault,
- obstacle halt with clear-hysteresis and resume.

It sits between the tracker/sonic front-ends and the PWM motor drivers.

Parameters:
- N_SENS, 5, number of tracker sensors; odd, 3..15; bit 0 = leftmost sensor.
- DUTY_W, 10, width of duty outputs.
- DUTY_FAST, 800, straight-line duty for both wheels.
- DUTY_STEP, 200, duty reduction per unit of line offset on the inner wheel.
- DUTY_SEARCH, 500, pivot duty used during search.
- FILT_LEN, 4, consecutive equal samples needed to accept a sensor change.
- LOST_TIMEOUT, 100, search cycles before FAULT.
- CLEAR_CYC, 8, consecutive stop_req-low cycles needed to leave HALT.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, run request; level-sensitive.
- sensors, input, N_SENS, raw tracker bits; 1 = on line.
- stop_req, input, 1, obstacle stop from the sonic block.
- left_duty, output, DUTY_W, left wheel PWM duty.
- right_duty, output, DUTY_W, right wheel PWM duty.
- left_dir, output, 2, 01 forward, 10 reverse, 00 brake.
- right_dir, output, 2, same encoding as left_dir.
- state_o, output, 3, current FSM state code.
- lost, output, 1, high while in SEARCH_L, SEARCH_R or FAULT.

Behaviour:
- Reset:
  - FSM to IDLE; filtered sensors = 0; last_side = CENTER; counters = 0.
  - All outputs 0: duty 0, dir 00, state_o IDLE, lost 0.
- Filter, per bit:
  - A per-bit counter counts consecutive cycles in which raw differs from filtered; it resets to 0 when raw equals filtered.
  - When the count reaches FILT_LEN, filtered takes the raw value on that edge.
  - A glitch shorter than FILT_LEN cycles never propagates.
- Offset:
  - Computed on filtered bits only, when at least one bit is set: lo = index of lowest set bit, hi = index of highest set bit.
  - off = lo + hi - (N_SENS-1), signed, range ±(N_SENS-1).
  - Negative off = line to the left.
- State codes: IDLE=0, TRACK=1, SEARCH_L=2, SEARCH_R=3, HALT=4, FAULT=5.
- Priority per cycle: rst > !enable > stop_req > sensor logic.
- IDLE:
  - enable=1 → TRACK.
  - Outputs zero.
- TRACK, at least one filtered bit set:
  - Both dir = 01.
  - off=0 → both duties DUTY_FAST.
  - off<0 → left = max(0, DUTY_FAST - |off|*DUTY_STEP), right = DUTY_FAST. off>0 is the mirror case.
  - Product computed at DUTY_W+4 bits, then clamped at 0; no wrap.
  - last_side updates to L (off<0) or R (off>0); it is unchanged when off=0.
- TRACK, no filtered bit set:
  - Go to SEARCH_L if last_side=L, SEARCH_R if last_side=R, FAULT if CENTER.
  - Search counter cleared on entry.
- SEARCH_L:
  - left_dir 10, right_dir 01, both duties DUTY_SEARCH. SEARCH_R is the mirror.
  - Counter increments each cycle.
  - Any filtered bit set → TRACK.
  - Otherwise, counter reaching LOST_TIMEOUT-1 → FAULT.
  - If sensor reacquisition and timeout occur in the same cycle, TRACK wins.
- HALT:
  - Entered from TRACK or SEARCH_x when stop_req=1; that state is saved as the return state.
  - Outputs: duties 0, dirs 00.
  - Search counter is frozen, not cleared.
  - A clear counter counts consecutive stop_req=0 cycles; any stop_req=1 resets it.
  - Reaching CLEAR_CYC → return to the saved state.
  - stop_req is ignored in IDLE and FAULT.
- FAULT:
  - Outputs zero, lost=1.
  - Exits only via enable=0 (→ IDLE) or rst.
- enable=0 in any state → IDLE next cycle; last_side and counters are cleared.
- Latency:
  - FSM and outputs are registered.
  - Outputs reflect the state/filtered values of the previous cycle.
  - A raw sensor change reaches the duty outputs FILT_LEN+1 cycles after it first appears.
- Reset mid-operation: rst asserted in any state gives all reset values on the next edge, regardless of enable.

Test Plan (defaults):
- Reset, then enable=1, sensors=00100 held → state_o 1; after filter latency, left_duty = right_duty = 800, dirs 01/01.
- sensors=00001 (off=-4) → left_duty 0, right_duty 800. sensors=00011 (off=-3) → left 200, right 800. With DUTY_STEP=300 and off=-4 → left clamps to 0, with no wrap.
- Single-cycle glitch 00100→01100→00100, and a 3-cycle glitch → duties unchanged. A 4-cycle change → update observed at cycle 5.
- Track with last_side=R, then sensors=00000 → SEARCH_R: left 01/500, right 10/500, lost=1. Line still absent after 100 cycles → FAULT with zero outputs. Repeat with line returning at cycle 60 → TRACK.
- stop_req pulse during TRACK → HALT with zero duties. stop_req toggled low 5 cycles, high 1, low 8 → resume TRACK exactly after the 8th low cycle. Same test from SEARCH_L → resumes with search counter preserved.
- enable dropped during HALT → IDLE; rst during SEARCH_R → all outputs 0 next cycle.
